// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter with bounded lock sharing the register-file write port
// between CPU writeback (0) and the peripheral/DMA loader (1).
module wb_port_arbiter #(
  parameter int unsigned AW        = 5,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_LOCK  = 4,
  parameter bit          DROP_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_lock,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_lock,
  output logic          req1_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_sel,
  input  logic          wr_ready,
  output logic          busy
);

  localparam int unsigned CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          wr_sel_q, wr_sel_d;
  logic          busy_q, busy_d;

  logic          slot_free, grant0, grant1, accept, acc_sel, acc_lock, drop;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;

  // Winner selection: owner-only while locked, priority on contention otherwise
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    slot_free = !wr_en_q || wr_ready;
    if (slot_free && rst_n) begin
      case (state_q)
        OWN0:    grant0 = req0_valid;
        OWN1:    grant1 = req1_valid;
        default: begin
          if (req0_valid && req1_valid) begin
            grant0 = !prio_q;
            grant1 = prio_q;
          end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
          end
        end
      endcase
    end
    accept   = grant0 || grant1;
    acc_sel  = grant1;
    acc_addr = grant1 ? req1_addr : req0_addr;
    acc_data = grant1 ? req1_data : req0_data;
    acc_lock = grant1 ? req1_lock : req0_lock;
    drop     = DROP_ZERO && (acc_addr == '0);
  end

  // Next-state: issued beat register, priority and lock ownership
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_sel_d   = wr_sel_q;

    if (accept) begin
      prio_d = !acc_sel;
      if (drop) begin
        wr_en_d = 1'b0;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = acc_addr;
        wr_data_d = acc_data;
        wr_sel_d  = acc_sel;
      end
    end else if (wr_ready) begin
      wr_en_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept && acc_lock) begin
          state_d    = acc_sel ? OWN1 : OWN0;
          lock_cnt_d = CW'(1);
        end
      end
      OWN0, OWN1: begin
        // Lock budget counts every owned cycle, stalls included
        if ((accept && !acc_lock) || (lock_cnt_q == LOCK_LAST)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          prio_d     = (state_q == OWN0);
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE) || wr_en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_sel_q   <= wr_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_sel     = wr_sel_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, with two
// instances (r0 drop enabled / disabled) checked against an ownership model.
module tb_wb_port_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned ML = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rv[2];
  logic          rl[2];
  logic [AW-1:0] ra[2];
  logic [DW-1:0] rd[2];
  logic          wr_ready;

  logic          o_r0[2], o_r1[2], o_en[2], o_sel[2], o_busy[2];
  logic [AW-1:0] o_addr[2];
  logic [DW-1:0] o_data[2];

  int checks = 0;
  int failures = 0;

  wb_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML), .DROP_ZERO(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_addr(ra[0]), .req0_data(rd[0]), .req0_lock(rl[0]), .req0_ready(o_r0[0]),
    .req1_valid(rv[1]), .req1_addr(ra[1]), .req1_data(rd[1]), .req1_lock(rl[1]), .req1_ready(o_r1[0]),
    .wr_en(o_en[0]), .wr_addr(o_addr[0]), .wr_data(o_data[0]), .wr_sel(o_sel[0]),
    .wr_ready(wr_ready), .busy(o_busy[0])
  );

  wb_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML), .DROP_ZERO(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_addr(ra[0]), .req0_data(rd[0]), .req0_lock(rl[0]), .req0_ready(o_r0[1]),
    .req1_valid(rv[1]), .req1_addr(ra[1]), .req1_data(rd[1]), .req1_lock(rl[1]), .req1_ready(o_r1[1]),
    .wr_en(o_en[1]), .wr_addr(o_addr[1]), .wr_data(o_data[1]), .wr_sel(o_sel[1]),
    .wr_ready(wr_ready), .busy(o_busy[1])
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Model: who owns the port and since which edge, plus the beat on wr_*
  int            owner[2] = '{-1, -1};
  int            acq[2]   = '{0, 0};
  bit            prio[2];
  bit            oen[2];
  logic [AW-1:0] oaddr[2];
  logic [DW-1:0] odata[2];
  bit            osel[2];
  int            cyc = 0;

  function automatic int winner(input int i);
    if (!rst_n) return -1;
    if (oen[i] && !wr_ready) return -1;
    if (owner[i] >= 0) return rv[owner[i]] ? owner[i] : -1;
    if (rv[0] && rv[1]) return int'(prio[i]);
    if (rv[0]) return 0;
    if (rv[1]) return 1;
    return -1;
  endfunction

  initial forever begin
    int w;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        owner[i] = -1; acq[i] = 0; prio[i] = 1'b0; oen[i] = 1'b0;
        oaddr[i] = '0; odata[i] = '0; osel[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        w = winner(i);
        if (w >= 0) begin
          prio[i] = (w == 0);
          if ((i == 0) && (ra[w] == '0)) oen[i] = 1'b0;
          else begin
            oen[i] = 1'b1; oaddr[i] = ra[w]; odata[i] = rd[w]; osel[i] = (w == 1);
          end
        end else if (wr_ready) oen[i] = 1'b0;
        if (owner[i] < 0) begin
          if (w >= 0 && rl[w]) begin owner[i] = w; acq[i] = cyc; end
        end else if ((w == owner[i] && !rl[w]) || (cyc - acq[i] == int'(ML) - 1)) begin
          prio[i] = (owner[i] == 0);
          owner[i] = -1;
        end
      end
      cyc++;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  initial forever begin
    int w;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      w = winner(i);
      chk($sformatf("u%0d.req0_ready", i), 64'(o_r0[i]), 64'(w == 0));
      chk($sformatf("u%0d.req1_ready", i), 64'(o_r1[i]), 64'(w == 1));
      chk($sformatf("u%0d.wr_en", i), 64'(o_en[i]), 64'(oen[i]));
      chk($sformatf("u%0d.wr_addr", i), 64'(o_addr[i]), 64'(oaddr[i]));
      chk($sformatf("u%0d.wr_data", i), 64'(o_data[i]), 64'(odata[i]));
      chk($sformatf("u%0d.wr_sel", i), 64'(o_sel[i]), 64'(osel[i]));
      chk($sformatf("u%0d.busy", i), 64'(o_busy[i]), 64'((owner[i] >= 0) || oen[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic l);
    rv[k] = v; ra[k] = a; rd[k] = d; rl[k] = l;
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 5'd0, 32'h0, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  initial begin
    int a0, a1, n;
    logic s0, s1;
    int t3_sel[6]  = '{0, 0, 0, 0, 1, 0};
    int t3_addr[6] = '{1, 2, 3, 4, 9, 5};

    idle_all();
    wr_ready = 1'b1;
    repeat (2) tick();
    chk("rst_wr_en", 64'(o_en[0]), 64'(0));
    chk("rst_busy", 64'(o_busy[0]), 64'(0));
    rst_n = 1'b1;
    tick();

    // Reset in the middle of an issued beat
    set_req(0, 1'b1, 5'd5, 32'h11, 1'b0);
    #1 chk("t1_first_ready", 64'(o_r0[0]), 64'(1));
    tick();
    wr_ready = 1'b0;
    chk("t1_wr_en_before_rst", 64'(o_en[0]), 64'(1));
    set_req(0, 1'b1, 5'd5, 32'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t1_rst_en", 64'(o_en[i]), 64'(0));
      chk("t1_rst_addr", 64'(o_addr[i]), 64'(0));
      chk("t1_rst_data", 64'(o_data[i]), 64'(0));
      chk("t1_rst_sel", 64'(o_sel[i]), 64'(0));
      chk("t1_rst_busy", 64'(o_busy[i]), 64'(0));
      chk("t1_rst_ready0", 64'(o_r0[i]), 64'(0));
    end
    wr_ready = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("t1_post_rst_en", 64'(o_en[0]), 64'(1));
    chk("t1_post_rst_addr", 64'(o_addr[0]), 64'(5));
    chk("t1_post_rst_data", 64'(o_data[0]), 64'(32'h55));
    set_req(1, 1'b1, 5'd3, 32'h33, 1'b0);
    tick();
    idle_all();

    // Contention without lock alternates one beat per cycle
    a0 = 10; a1 = 20;
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, AW'(a0), DW'(a0), 1'b0);
      set_req(1, 1'b1, AW'(a1), DW'(a1), 1'b0);
      #1;
      s0 = o_r0[0]; s1 = o_r1[0];
      chk("t2_ready0", 64'(s0), 64'(c % 2 == 0));
      chk("t2_ready1", 64'(s1), 64'(c % 2 == 1));
      tick();
      chk("t2_sel", 64'(o_sel[0]), 64'(c % 2));
      chk("t2_addr", 64'(o_addr[0]), 64'((c % 2 == 1) ? 20 + c / 2 : 10 + c / 2));
      chk("t2_en", 64'(o_en[0]), 64'(1));
      if (s0) a0++;
      if (s1) a1++;
    end
    idle_all();

    // Locked requester 0 with requester 1 always waiting
    n = 1;
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1'b1, AW'(n), DW'(n), 1'b1);
      set_req(1, 1'b1, 5'd9, 32'h9, 1'b0);
      #1 s0 = o_r0[0];
      tick();
      chk("t3_sel", 64'(o_sel[0]), 64'(t3_sel[c]));
      chk("t3_addr", 64'(o_addr[0]), 64'(t3_addr[c]));
      if (s0) n++;
    end
    idle_all();
    repeat (5) tick();

    // Backpressure holds the issued beat and blocks both requesters
    set_req(0, 1'b1, 5'd7, 32'h77, 1'b0);
    tick();
    wr_ready = 1'b0;
    set_req(0, 1'b1, 5'd12, 32'hC, 1'b0);
    set_req(1, 1'b1, 5'd13, 32'hD, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_stall_ready0", 64'(o_r0[0]), 64'(0));
      chk("t4_stall_ready1", 64'(o_r1[0]), 64'(0));
      chk("t4_stall_en", 64'(o_en[0]), 64'(1));
      chk("t4_stall_addr", 64'(o_addr[0]), 64'(7));
      chk("t4_stall_data", 64'(o_data[0]), 64'(32'h77));
      tick();
    end
    wr_ready = 1'b1;
    #1 chk("t4_release_ready1", 64'(o_r1[0]), 64'(1));
    tick();
    chk("t4_next_addr", 64'(o_addr[0]), 64'(13));
    chk("t4_next_sel", 64'(o_sel[0]), 64'(1));
    idle_all();
    tick();

    // r0 beat: dropped by u0, issued by u1
    set_req(0, 1'b1, 5'd2, 32'h2, 1'b0);
    tick();
    idle_all();
    tick();
    set_req(1, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    #1;
    chk("t5_ready1_u0", 64'(o_r1[0]), 64'(1));
    chk("t5_ready1_u1", 64'(o_r1[1]), 64'(1));
    tick();
    idle_all();
    chk("t5_drop_en", 64'(o_en[0]), 64'(0));
    chk("t5_drop_addr_held", 64'(o_addr[0]), 64'(2));
    chk("t5_drop_sel_held", 64'(o_sel[0]), 64'(0));
    chk("t5_nodrop_en", 64'(o_en[1]), 64'(1));
    chk("t5_nodrop_addr", 64'(o_addr[1]), 64'(0));
    chk("t5_nodrop_data", 64'(o_data[1]), 64'(32'hDEAD));
    chk("t5_nodrop_sel", 64'(o_sel[1]), 64'(1));
    set_req(0, 1'b1, 5'd14, 32'hE, 1'b0);
    set_req(1, 1'b1, 5'd15, 32'hF, 1'b0);
    #1;
    chk("t5_prio_u0", 64'(o_r0[0]), 64'(1));
    chk("t5_prio_u1", 64'(o_r0[1]), 64'(1));
    tick();
    idle_all();
    tick();

    // Lock held by an idle owner expires after MAX_LOCK cycles
    set_req(1, 1'b1, 5'd8, 32'h88, 1'b1);
    #1 chk("t6_lock_ready1", 64'(o_r1[0]), 64'(1));
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0, 1'b0);
    set_req(0, 1'b1, 5'd6, 32'h66, 1'b0);
    n = 1;
    while (n <= 10) begin
      #1;
      if (o_r0[0]) break;
      tick();
      n++;
    end
    chk("t6_grant_delay", 64'(n), 64'(ML));
    tick();
    idle_all();
    tick();

    // Random traffic against the model
    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        rv[k] = ($urandom_range(0, 3) != 0);
        ra[k] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        rd[k] = $urandom;
        rl[k] = ($urandom_range(0, 2) == 0);
      end
      wr_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle_all();
    wr_ready = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
